// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debouncer bank.
// Default timing constants assume the 100 MHz board clock.
package debounce_pkg;

  localparam int DEB_CNT_100MHZ    = 1_000_000;   // 10 ms
  localparam int HOLD_CNT_100MHZ   = 50_000_000;  // 500 ms
  localparam int REPEAT_CNT_100MHZ = 10_000_000;  // 100 ms

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_st_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-FF synchroniser, debounce counter, press/release strobes
// and the long-press / auto-repeat FSM.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEB_CNT    = 8,
  parameter int HOLD_CNT   = 20,
  parameter int REPEAT_CNT = 5,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic pb_raw_i,
  output logic state_o,
  output logic down_o,
  output logic up_o,
  output logic long_o,
  output logic repeat_o,
  output logic press_d_o
);

  localparam int DW = cnt_w(DEB_CNT);
  localparam int HW = cnt_w(max2(HOLD_CNT, REPEAT_CNT));
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CNT - 1);
  localparam logic [HW-1:0] REP_MAX  = HW'((REPEAT_CNT > 0) ? REPEAT_CNT - 1 : 0);

  logic          s0_q, s1_q;
  logic          state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic          down_q, up_q, long_q, long_d, rep_q, rep_d;
  hold_st_e      st_q, st_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          sat_q, sat_d;
  logic          mismatch, flip, press, release_ev;

  assign mismatch   = s1_q != state_q;
  assign flip       = mismatch && (deb_q == DEB_MAX);
  assign press      = flip && !state_q;
  assign release_ev = flip && state_q;
  assign state_d    = state_q ^ flip;
  assign deb_d      = (!mismatch || flip) ? '0 : deb_q + 1'b1;

  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    sat_d  = sat_q;
    long_d = 1'b0;
    rep_d  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        hcnt_d = '0;
        sat_d  = 1'b0;
        if (press) st_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (release_ev) begin
          st_d   = ST_IDLE;
          hcnt_d = '0;
          sat_d  = 1'b0;
        end else if (!sat_q) begin
          if (hcnt_q == HOLD_MAX) begin
            long_d = 1'b1;
            hcnt_d = '0;
            // Without repeat, park in HOLD with further strobes suppressed.
            if (REPEAT_CNT > 0) st_d = ST_REPEAT;
            else                sat_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (release_ev) begin
          st_d   = ST_IDLE;
          hcnt_d = '0;
        end else if (hcnt_q == REP_MAX) begin
          rep_d  = 1'b1;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        st_d   = ST_IDLE;
        hcnt_d = '0;
        sat_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      state_q <= 1'b0;
      deb_q   <= '0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      st_q    <= ST_IDLE;
      hcnt_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      s0_q    <= pb_raw_i ^ (ACTIVE_LOW != 0);
      s1_q    <= s0_q;
      state_q <= state_d;
      deb_q   <= deb_d;
      down_q  <= press;
      up_q    <= release_ev;
      long_q  <= long_d;
      rep_q   <= rep_d;
      st_q    <= st_d;
      hcnt_q  <= hcnt_d;
      sat_q   <= sat_d;
    end
  end

  assign state_o   = state_q;
  assign down_o    = down_q;
  assign up_o      = up_q;
  assign long_o    = long_q;
  assign repeat_o  = rep_q;
  assign press_d_o = press;

endmodule

// File: rtl/debounce_bank.sv
// N independent debounced button channels plus a registered OR of press strobes.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DEB_CNT    = DEB_CNT_100MHZ,
  parameter int HOLD_CNT   = HOLD_CNT_100MHZ,
  parameter int REPEAT_CNT = REPEAT_CNT_100MHZ,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pb_raw,
  output logic [N_CH-1:0] pb_state,
  output logic [N_CH-1:0] pb_down,
  output logic [N_CH-1:0] pb_up,
  output logic [N_CH-1:0] pb_long,
  output logic [N_CH-1:0] pb_repeat,
  output logic            any_down
);

  logic [N_CH-1:0] press_d;
  logic            any_down_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DEB_CNT    (DEB_CNT),
      .HOLD_CNT   (HOLD_CNT),
      .REPEAT_CNT (REPEAT_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst_n_i   (reset),
      .pb_raw_i  (pb_raw[g]),
      .state_o   (pb_state[g]),
      .down_o    (pb_down[g]),
      .up_o      (pb_up[g]),
      .long_o    (pb_long[g]),
      .repeat_o  (pb_repeat[g]),
      .press_d_o (press_d[g])
    );
  end

  // Registered from the same next-state as pb_down so both rise together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) any_down_q <= 1'b0;
    else        any_down_q <= |press_d;
  end

  assign any_down = any_down_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench: N_CH=4, DEB_CNT=8, HOLD_CNT=20, REPEAT_CNT=5 active-low,
// plus a single-channel REPEAT_CNT=0 build.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pb_raw;
  logic [3:0] pb_state, pb_down, pb_up, pb_long, pb_repeat;
  logic       any_down;
  logic [0:0] nr_raw, nr_state, nr_down, nr_up, nr_long, nr_repeat;
  logic       nr_any;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(4), .DEB_CNT(8), .HOLD_CNT(20), .REPEAT_CNT(5), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .pb_raw(pb_raw), .pb_state(pb_state), .pb_down(pb_down),
    .pb_up(pb_up), .pb_long(pb_long), .pb_repeat(pb_repeat), .any_down(any_down)
  );

  debounce_bank #(.N_CH(1), .DEB_CNT(8), .HOLD_CNT(20), .REPEAT_CNT(0), .ACTIVE_LOW(1)) dut_nr (
    .clk(clk), .reset(reset), .pb_raw(nr_raw), .pb_state(nr_state), .pb_down(nr_down),
    .pb_up(nr_up), .pb_long(nr_long), .pb_repeat(nr_repeat), .any_down(nr_any)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    pb_raw = 4'hF;
    nr_raw = 1'b1;
    #23;
    n_cmp++;
    if ({pb_state, pb_down, pb_up, pb_long, pb_repeat, any_down} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {pb_state, pb_down, pb_up, pb_long, pb_repeat, any_down});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if ({pb_state, pb_down, pb_up, pb_long, pb_repeat, any_down, nr_state} !== 22'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h expected 0",
               {pb_state, pb_down, pb_up, pb_long, pb_repeat, any_down, nr_state});
    end
  endtask

  task automatic test_clean_press();
    int first_st = -1, first_dn = -1, n_dn = 0, n_any = 0, n_other = 0, n_up = 0, up_e = -1, n_long = 0;
    pb_raw[0] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (pb_state[0] && first_st < 0) first_st = e;
      if (pb_down[0]) begin n_dn++; if (first_dn < 0) first_dn = e; end
      if (any_down) n_any++;
      if ((pb_state[3:1] | pb_down[3:1] | pb_up[3:1]) != 3'b0) n_other++;
    end
    chk("clean_state_edge", first_st, 9);
    chk("clean_down_edge", first_dn, 9);
    chk("clean_down_count", n_dn, 1);
    chk("clean_any_count", n_any, 1);
    chk("clean_other_channels", n_other, 0);
    pb_raw[0] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (pb_up[0]) begin n_up++; up_e = e; end
      if (pb_long[0]) n_long++;
    end
    chk("clean_up_edge", up_e, 9);
    chk("clean_up_count", n_up, 1);
    chk("clean_no_long", n_long, 0);
    chk("clean_state_released", int'(pb_state[0]), 0);
  endtask

  task automatic test_glitch();
    int bad = 0, first_st = -1, n_dn = 0;
    for (int r = 0; r < 5; r++) begin
      pb_raw[1] = 1'b0;
      repeat (7) begin tick(); if (pb_state[1] | pb_down[1]) bad++; end
      pb_raw[1] = 1'b1;
      tick();
      if (pb_state[1] | pb_down[1]) bad++;
    end
    chk("glitch_rejected", bad, 0);
    pb_raw[1] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (pb_state[1] && first_st < 0) first_st = e;
      if (pb_down[1]) n_dn++;
    end
    chk("glitch_then_press_edge", first_st, 9);
    chk("glitch_then_press_down", n_dn, 1);
    pb_raw[1] = 1'b1;
    repeat (12) tick();
    chk("glitch_released", int'(pb_state[1]), 0);
  endtask

  task automatic test_long_repeat();
    int dn_e = -1, n_long = 0, long_e = -1, n_rep = 0, rep_first = -1, rep_last = -1;
    int rep_bad = 0, n_up = 0, up_e = -1;
    pb_raw[2] = 1'b0;
    for (int e = 0; e < 100; e++) begin
      tick();
      if (e == 59) pb_raw[2] = 1'b1;
      if (pb_down[2]) dn_e = e;
      if (pb_long[2]) begin n_long++; long_e = e; end
      if (pb_repeat[2]) begin
        n_rep++;
        if (rep_first < 0) rep_first = e;
        rep_last = e;
        if (e < 34 || (e - 34) % 5 != 0) rep_bad++;
      end
      if (pb_up[2]) begin n_up++; up_e = e; end
    end
    chk("long_down_edge", dn_e, 9);
    chk("long_count", n_long, 1);
    chk("long_edge", long_e, 29);
    chk("repeat_count", n_rep, 7);
    chk("repeat_first", rep_first, 34);
    chk("repeat_last", rep_last, 64);
    chk("repeat_spacing", rep_bad, 0);
    chk("long_up_count", n_up, 1);
    chk("long_up_edge", up_e, 69);
  endtask

  task automatic test_no_repeat();
    int n_long = 0, long_e = -1, n_rep = 0, drop = 0;
    nr_raw = 1'b0;
    for (int e = 0; e < 120; e++) begin
      tick();
      if (nr_long[0]) begin n_long++; long_e = e; end
      if (nr_repeat[0]) n_rep++;
      if (e >= 9 && !nr_state[0]) drop++;
    end
    chk("norep_long_count", n_long, 1);
    chk("norep_long_edge", long_e, 29);
    chk("norep_repeat_count", n_rep, 0);
    chk("norep_state_held", drop, 0);
    nr_raw = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    int d0 = -1, d3 = -1, n_any = 0, u3 = -1, n_u3 = 0, n_u0 = 0, dn_rel = 0;
    pb_raw[0] = 1'b0;
    pb_raw[3] = 1'b0;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (pb_down[0]) d0 = e;
      if (pb_down[3]) d3 = e;
      if (any_down) n_any++;
    end
    chk("simul_down0_edge", d0, 9);
    chk("simul_down3_edge", d3, 9);
    chk("simul_any_count", n_any, 1);
    pb_raw[3] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (pb_up[3]) begin n_u3++; u3 = e; end
      if (pb_up[0]) n_u0++;
      if (pb_down != 4'b0 || any_down) dn_rel++;
    end
    chk("simul_up3_edge", u3, 9);
    chk("simul_up3_count", n_u3, 1);
    chk("simul_up0_quiet", n_u0, 0);
    chk("simul_no_down_on_release", dn_rel, 0);
    chk("simul_state", int'(pb_state), 1);
    pb_raw[0] = 1'b1;
    repeat (14) tick();
  endtask

  task automatic test_async_reset();
    int dn_e = -1, long_e = -1, n_dn = 0;
    pb_raw[2] = 1'b0;
    repeat (41) tick();
    chk("areset_pre_state", int'(pb_state[2]), 1);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({pb_state, pb_down, pb_up, pb_long, pb_repeat, any_down} !== 21'd0) begin
      n_err++;
      $display("FAIL areset_immediate: got %h expected 0",
               {pb_state, pb_down, pb_up, pb_long, pb_repeat, any_down});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int e = 0; e < 36; e++) begin
      tick();
      if (pb_down[2]) begin n_dn++; dn_e = e; end
      if (pb_long[2] && long_e < 0) long_e = e;
    end
    chk("areset_down_edge", dn_e, 9);
    chk("areset_down_count", n_dn, 1);
    chk("areset_long_edge", long_e, 29);
    pb_raw[2] = 1'b1;
    repeat (14) tick();
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_repeat();
    test_no_repeat();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised N-channel push-button debouncer; successor to the single-channel debouncer used for the tennis game buttons.
- Each channel has:
  - a 2-FF synchroniser
  - a configurable debounce counter
  - a clean level output plus press/release strobes
  - long-press detection with optional auto-repeat
- Sits between raw board buttons and game/control FSMs; all outputs are synchronous to clk.

Parameters:
- N_CH, 4, number of independent button channels (1..16)
- DEB_CNT, 1000000, consecutive disagreeing cycles required to accept a new level (>=2)
- HOLD_CNT, 50000000, cycles of accepted press before long-press strobe (>=1)
- REPEAT_CNT, 10000000, auto-repeat period after long press; 0 disables repeat
- ACTIVE_LOW, 1, 1 = raw input is active-low (inverted at synchroniser input); 0 = active-high

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- pb_raw  input  N_CH  raw asynchronous button pins
- pb_state  output  N_CH  debounced level, 1 = pressed
- pb_down  output  N_CH  1-cycle strobe on accepted press
- pb_up  output  N_CH  1-cycle strobe on accepted release
- pb_long  output  N_CH  1-cycle strobe when press held HOLD_CNT cycles
- pb_repeat  output  N_CH  1-cycle strobe every REPEAT_CNT cycles after pb_long while held
- any_down  output  1  OR of pb_down (registered with it)

Behaviour:
- Reset (reset=0, async): all outputs 0; synchronisers, debounce and hold counters 0. Deassertion is synchronised externally; no reset synchroniser inside.
- Synchroniser: s0 <= pb_raw[i] XOR ACTIVE_LOW; s1 <= s0. Only s1 is used downstream.
- Debounce counter (width $clog2(DEB_CNT)):
  - s1 == pb_state → cnt <= 0.
  - Otherwise cnt increments.
  - When cnt == DEB_CNT-1 and a mismatch is still present: pb_state toggles and cnt <= 0.
  - Any single cycle of s1 == pb_state restarts the count, so glitches shorter than DEB_CNT cycles are fully rejected.
- Latency: the first clk edge sampling a new stable pin level is edge 0. pb_state changes at edge DEB_CNT+1; the matching pb_down/pb_up is high for exactly the cycle following that edge.
- Strobes: pb_down = registered (state 0→1); pb_up = registered (1→0). They are never both high on one channel, and never high outside a state change.
- Hold/repeat FSM per channel:
  - States IDLE, HOLD, REPEAT.
  - IDLE: hold_cnt = 0. Leaves on an accepted press → HOLD.
  - HOLD: hold_cnt increments each cycle pb_state=1. When hold_cnt reaches HOLD_CNT-1: pulse pb_long, hold_cnt <= 0, go to REPEAT if REPEAT_CNT>0, else stay HOLD with the counter frozen (saturated, no further strobes).
  - REPEAT: hold_cnt counts to REPEAT_CNT-1, then pulses pb_repeat and wraps to 0.
  - Any accepted release → IDLE, counter cleared, no strobe on that cycle except pb_up.
- Hold counter width: $clog2(max(HOLD_CNT, REPEAT_CNT)). No wrap-around in HOLD.
- Simultaneous events: channels are fully independent. Several channels may strobe in the same cycle; any_down then reflects the OR.
- Mid-operation reset: async reset drops all strobes and state immediately. After release, a button still held produces a fresh press after DEB_CNT+1 cycles.

Decomposition:
- Package debounce_pkg: clog2-based width helper function, state encoding for IDLE/HOLD/REPEAT, default timing constants for the 100 MHz board clock (10 ms debounce, 500 ms long press, 100 ms repeat).
- Sub-module debounce_channel: one synchroniser, debounce counter and hold FSM. debounce_bank is a generate loop of N_CH instances plus the any_down OR register.

Test Plan:
- N_CH=4, DEB_CNT=8, HOLD_CNT=20, REPEAT_CNT=5, ACTIVE_LOW=1.
- Clean press: drive pb_raw[0] 1→0 at edge 0 and hold → pb_state[0]=1 after edge 9; pb_down[0] and any_down high for exactly 1 cycle; other channels stay 0.
- Glitch rejection: pulse pb_raw[1] low for 7 cycles, high 1 cycle, repeated 5 times → pb_state[1], pb_down[1] never assert. Then hold low 8 cycles → press accepted at edge 9.
- Long press/repeat: hold ch2 pressed 60 cycles after acceptance → pb_long at accepted+20; pb_repeat at +25, +30, … +55; release gives pb_up once, no further repeats.
- REPEAT_CNT=0 build: hold 100 cycles → exactly one pb_long, zero pb_repeat.
- Simultaneous channels: press ch0 and ch3 on the same edge → both pb_down in the same cycle, any_down high 1 cycle. Release ch3 only → pb_up[3] alone.
- Async reset: assert reset mid-hold on ch2 (REPEAT state) → all outputs 0 within the same cycle. Deassert with button still held → pb_down[2] after 9 cycles, pb_long 20 cycles later.
